// File: rtl/mem_wb_skid_stage.sv
// MEM/WB pipeline register with a 2-entry skid buffer; 1-cycle latency when empty.
// Backpressure: in_ready comes only from the skid flop, so out_ready never reaches in_ready combinationally.
module mem_wb_skid_stage #(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int NDATA  = 2,
  parameter int REG_W  = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [NDATA*DATA_W-1:0] in_data,
  input  logic [REG_W-1:0]        in_reg,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [NDATA*DATA_W-1:0] out_data,
  output logic [REG_W-1:0]        out_reg,
  output logic [1:0]              occupancy
);

  logic                    mValid;
  logic [CTRL_W-1:0]       mCtrl;
  logic [NDATA*DATA_W-1:0] mData;
  logic [REG_W-1:0]        mReg;

  logic                    sValid;
  logic [CTRL_W-1:0]       sCtrl;
  logic [NDATA*DATA_W-1:0] sData;
  logic [REG_W-1:0]        sReg;

  logic accept;
  logic drain;

  assign accept = in_valid & in_ready;
  assign drain  = mValid & out_ready;

  assign in_ready  = ~sValid;
  assign out_valid = mValid;
  // Gate ctrl so a bubble can never carry RegWrite into WB.
  assign out_ctrl  = mValid ? mCtrl : '0;
  assign out_data  = mData;
  assign out_reg   = mReg;
  assign occupancy = {1'b0, mValid} + {1'b0, sValid};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mValid <= 1'b0;
      mCtrl  <= '0;
      mData  <= '0;
      mReg   <= '0;
      sValid <= 1'b0;
      sCtrl  <= '0;
      sData  <= '0;
      sReg   <= '0;
    end else if (flush) begin
      mValid <= 1'b0;
      sValid <= 1'b0;
      mCtrl  <= '0;
      sCtrl  <= '0;
    end else if (!mValid || drain) begin
      // Skid holds the older entry, so it always wins; accept is impossible while skid is full.
      if (sValid) begin
        mValid <= 1'b1;
        mCtrl  <= sCtrl;
        mData  <= sData;
        mReg   <= sReg;
        sValid <= 1'b0;
        sCtrl  <= '0;
      end else if (accept) begin
        mValid <= 1'b1;
        mCtrl  <= in_ctrl;
        mData  <= in_data;
        mReg   <= in_reg;
      end else begin
        mValid <= 1'b0;
        mCtrl  <= '0;
      end
    end else if (accept) begin
      sValid <= 1'b1;
      sCtrl  <= in_ctrl;
      sData  <= in_data;
      sReg   <= in_reg;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed and random checks of mem_wb_skid_stage against a queue-based reference model.
module tb_mem_wb_skid_stage;

  typedef struct packed {
    logic [2:0]  c;
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_reg = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_reg;
  logic [1:0]  occupancy;

  logic        nInReady;
  logic        nOutValid;
  logic [0:0]  nOutCtrl;
  logic [31:0] nOutData;
  logic [4:0]  nOutReg;
  logic [1:0]  nOcc;

  int checks = 0;
  int failures = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  mem_wb_skid_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .in_reg(in_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_reg(out_reg),
    .occupancy(occupancy)
  );

  // Narrow instance fed the same handshake, to exercise NDATA=1 / CTRL_W=1.
  mem_wb_skid_stage #(.CTRL_W(1), .DATA_W(32), .NDATA(1), .REG_W(5)) uNarrow (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(nInReady),
    .in_ctrl(in_ctrl[0:0]), .in_data(in_data[31:0]), .in_reg(in_reg),
    .out_valid(nOutValid), .out_ready(out_ready),
    .out_ctrl(nOutCtrl), .out_data(nOutData), .out_reg(nOutReg),
    .occupancy(nOcc)
  );

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [4:0] r, input logic [63:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_reg   = r;
    in_data  = d;
  endtask

  initial begin
    logic acc;
    logic drn;

    // Reset state
    #2 reset = 1'b0;
    #1;
    check("rst_vld", 96'(out_valid), 96'd0);
    check("rst_rdy", 96'(in_ready), 96'd1);
    check("rst_occ", 96'(occupancy), 96'd0);
    check("rst_fields", {out_ctrl, out_reg, out_data}, 96'd0);
    #3 reset = 1'b1;
    step();

    // Streaming: one entry per cycle, 1-cycle lag
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 3'(i), 5'(i), {32'(i) * 32'h0101_0101, ~32'(i)});
      step();
      check("stream_reg", 96'(out_reg), 96'(i));
      check("stream_ctrl_data", {out_ctrl, out_data}, {3'(i), 32'(i) * 32'h0101_0101, ~32'(i)});
      check("stream_occ_rdy_vld", {occupancy, in_ready, out_valid}, {2'd1, 1'b1, 1'b1});
      check("narrow_out", {nOutValid, nOutCtrl, nOutReg, nOutData, nOcc, nInReady},
            {1'b1, 1'(i), 5'(i), ~32'(i), 2'd1, 1'b1});
    end
    drive(1'b0, 3'b111, 5'd0, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bubble_ctrl", 96'(out_ctrl), 96'd0);
      check("bubble_vld_occ", {out_valid, occupancy}, {1'b0, 2'd0});
    end

    // Backpressure
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 5'd1, 64'h1);
    step();
    check("bp1", {out_reg, occupancy, in_ready}, {5'd1, 2'd1, 1'b1});
    drive(1'b1, 3'b010, 5'd2, 64'h2);
    step();
    check("bp2", {out_reg, occupancy, in_ready}, {5'd2 - 5'd1, 2'd2, 1'b0});
    drive(1'b1, 3'b011, 5'd3, 64'h3);
    step();
    check("bp3_hold", {out_reg, out_ctrl, out_data, occupancy, in_ready},
          {5'd1, 3'b001, 64'h1, 2'd2, 1'b0});
    out_ready = 1'b1;
    step();
    check("bp_drain2", {out_reg, occupancy, in_ready}, {5'd2, 2'd1, 1'b1});
    step();
    check("bp_drain3", {out_reg, out_ctrl, occupancy, in_ready}, {5'd3, 3'b011, 2'd1, 1'b1});
    drive(1'b0, 3'b000, 5'd0, 64'd0);
    step();
    check("bp_empty", {out_valid, occupancy}, {1'b0, 2'd0});

    // Flush with input present
    out_ready = 1'b0;
    drive(1'b1, 3'b101, 5'd4, 64'h4);
    step();
    drive(1'b1, 3'b111, 5'd5, 64'h5);
    step();
    check("fl_full", 96'(occupancy), 96'd2);
    flush = 1'b1;
    drive(1'b1, 3'b111, 5'd9, 64'h9);
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 5'd0, 64'd0);
    check("fl_after", {out_valid, out_ctrl, occupancy, in_ready}, {1'b0, 3'b000, 2'd0, 1'b1});
    out_ready = 1'b1;
    step();
    check("fl_no9", {out_valid, out_ctrl}, {1'b0, 3'b000});

    // Asynchronous reset with two entries held
    out_ready = 1'b0;
    drive(1'b1, 3'b110, 5'd10, 64'hA);
    step();
    drive(1'b1, 3'b110, 5'd11, 64'hB);
    step();
    drive(1'b0, 3'b000, 5'd0, 64'd0);
    check("ar_pre", 96'(occupancy), 96'd2);
    #2 reset = 1'b0;
    #1;
    check("ar_now", {out_valid, out_ctrl, out_reg, out_data, in_ready, occupancy},
          {1'b0, 3'b000, 5'd0, 64'd0, 1'b1, 2'd0});
    #2 reset = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 3'b101, 5'd7, {32'h1111_1111, 32'hCAFE_F00D});
    step();
    check("ar_first", {out_valid, out_ctrl, out_reg, out_data},
          {1'b1, 3'b101, 5'd7, 32'h1111_1111, 32'hCAFE_F00D});
    drive(1'b0, 3'b000, 5'd0, 64'd0);
    step();

    // Random traffic against queue model
    q.delete();
    for (int n = 0; n < 10000; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 99) < 5);
      in_ctrl   = 3'($urandom);
      in_reg    = 5'($urandom);
      in_data   = {$urandom, $urandom};
      check("rnd_occ", 96'(occupancy), 96'(q.size()));
      check("rnd_rdy_vld", {in_ready, out_valid}, {q.size() < 2, q.size() != 0});
      if (q.size() != 0)
        check("rnd_out", {out_ctrl, out_reg, out_data}, 96'(q[0]));
      else
        check("rnd_bubble", 96'(out_ctrl), 96'd0);
      if (flush) begin
        q.delete();
      end else begin
        acc = in_valid && (q.size() < 2);
        drn = (q.size() != 0) && out_ready;
        if (drn) void'(q.pop_front());
        if (acc) q.push_back({in_ctrl, in_reg, in_data});
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid_stage.md
Name: mem_wb_skid_stage

Overview:
- Parametrised successor to the fixed MEM/WB pipeline register.
- Carries control bits, NDATA data words and a destination register index from the MEM stage to the WB stage.
- Uses a valid/ready handshake backed by a 2-entry skid buffer, so a WB-side stall never drops data and never needs a combinational path from out_ready to in_ready.
- A synchronous flush turns everything in flight into bubbles whose control bits read as zero.

Parameters:
- CTRL_W, 3: control bit count (e.g. RegWrite, MemtoReg, hilowrite).
- DATA_W, 32: width of each data word.
- NDATA, 2: number of data words (e.g. aluout, readdata).
- REG_W, 5: destination register index width.

Ports:
- clk, in, 1: single clock; all state changes on the rising edge.
- reset, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous kill of all in-flight entries.
- in_valid, in, 1: MEM stage presents an entry.
- in_ready, out, 1: stage can accept; driven only from a register.
- in_ctrl, in, CTRL_W: control bits.
- in_data, in, NDATA*DATA_W: word k occupies bits [k*DATA_W +: DATA_W].
- in_reg, in, REG_W: destination register.
- out_valid, out, 1: entry available to WB.
- out_ready, in, 1: WB consumes the entry.
- out_ctrl, out, CTRL_W: control bits, forced to 0 when out_valid=0.
- out_data, out, NDATA*DATA_W: data words.
- out_reg, out, REG_W: destination register.
- occupancy, out, 2: number of valid entries, 0..2.

Behaviour:
- Storage:
  - Main entry (m_valid, payload): drives the outputs.
  - Skid entry (s_valid, payload).
  - out_valid = m_valid; in_ready = ~s_valid; occupancy = m_valid + s_valid.
- Handshakes:
  - accept = in_valid & in_ready.
  - drain = m_valid & out_ready.
- Reset (reset=0, asynchronous):
  - m_valid, s_valid, and all ctrl, data and reg fields go to 0.
  - Consequently out_valid=0, out_ctrl=0, out_data=0, out_reg=0, in_ready=1, occupancy=0.
  - Reset asserted mid-transfer discards both entries immediately.
  - The first accept is possible on the first rising edge after reset deasserts.
- Flush:
  - flush=1 at an edge clears m_valid and s_valid and zeroes the stored ctrl fields.
  - Data and reg fields may hold their values.
  - Flush overrides accept: an input presented in the flush cycle is dropped, even when in_ready=1.
  - In the cycle after a flush, in_ready=1 and out_valid=0.
- Next-state when flush=0, evaluated in priority order:
  1. Main empty, or drain: main loads skid if s_valid (skid clears), else the input if accept, else main clears.
     - In this case, if s_valid and accept are both true, the input moves into skid. This cannot occur, because accept requires s_valid=0.
  2. Main full, no drain, accept: input goes to skid; s_valid=1.
  3. Otherwise: hold.
- Latency and throughput:
  - An entry accepted at edge N appears on the outputs in cycle N+1 (1-cycle latency when the stage is empty).
  - Sustained throughput is 1 entry/cycle while out_ready=1.
- Stall behaviour:
  - out_ready=0 with main full: one further entry is absorbed into skid, then in_ready falls at the next edge.
  - Ordering is strictly FIFO; no entry is duplicated or lost.
- Output stability: while out_valid=1 and out_ready=0, the out_* values must not change.
- Bubbles: out_ctrl=0 whenever out_valid=0, so WB never sees RegWrite on a bubble.
- Width rules:
  - All fields are copied verbatim; there is no arithmetic.
  - occupancy never exceeds 2.
  - Parameters NDATA=1 and CTRL_W=1 must elaborate.

Test Plan:
- Reset:
  - Stimulus: drive reset=0 mid-stream with 2 entries held.
  - Required: outputs go to 0 immediately; in_ready=1; occupancy=0. After release, accepting ctrl=3'b101, reg=5'd7, data={32'h1111_1111, 32'hCAFE_F00D} makes those values appear on out_* one cycle later with out_valid=1.
- Streaming:
  - Stimulus: out_ready=1, in_valid=1 for 8 cycles with reg=1..8.
  - Required: out_reg sequence 1..8 at one per cycle, 1-cycle lag; occupancy stays 1; in_ready never falls.
- Backpressure:
  - Stimulus: out_ready=0 while sending reg=1,2,3.
  - Required: reg 1 sits in main, reg 2 in skid; in_ready=0 from the edge after reg 2; reg 3 is not accepted; occupancy=2; out_reg stays 1.
  - Then raise out_ready: out_reg shows 1, 2, 3 on consecutive cycles, and in_ready returns to 1 one cycle after the skid drains.
- Flush:
  - Stimulus: occupancy=2, then flush=1 together with in_valid=1 (reg=9).
  - Required: next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; reg 9 never appears.
- Bubble control:
  - Stimulus: in_valid=0 with in_ctrl=3'b111 held on the input.
  - Required: out_ctrl stays 3'b000 throughout.
- Random:
  - Stimulus: 10k cycles of random in_valid, out_ready and flush (flush at 5% probability).
  - Required: a scoreboard confirms in-order delivery with no loss except flushed entries; out_* are stable while stalled.
